alu_multicycle: RTL and testbench

Parametrised, registered successor to the single-cycle datapath ALU. It keeps the same 3-bit operation encoding and the same result/zero outputs. It adds a valid/ready handshake, registered outputs and an iterative shift-add multiplier, so MUL no longer sits in the critical path. It sits in the EX stage; the hazard unit stalls the pipeline while ready_o is low.

---
 rtl/alu_multicycle_if.sv | 24 ++
 rtl/alu_multicycle.sv | 122 ++++++++++++
 tb/tb_alu_multicycle.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Request/result bus of the multicycle EX-stage ALU.
// The master drives requests and the slave (the ALU) returns results.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             Zero_o;

  modport master (
    output valid_i, data1_i, data2_i, ALUCtrl_i,
    input  ready_o, valid_o, data_o, Zero_o
  );

  modport slave (
    input  valid_i, data1_i, data2_i, ALUCtrl_i,
    output ready_o, valid_o, data_o, Zero_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier that holds ready_o low for WIDTH cycles.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_multicycle_if.slave   bus
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                   state_q, state_nx;
  logic [CNT_W-1:0]         cnt_q;
  logic                     accept, last_iter, ready;
  logic                     res_we;
  logic signed [WIDTH-1:0]  res_nx;
  logic signed [WIDTH-1:0]  mcand_p0, acc_p0, acc_step;
  logic [WIDTH-1:0]         mplier_p0;
  logic signed [WIDTH-1:0]  res_p1;
  logic                     zero_p1, vld_p1;

  function automatic logic signed [WIDTH-1:0] alu_op(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic [SHAMT_W-1:0]      sh;
    logic signed [WIDTH-1:0] r;
    sh = b[SHAMT_W-1:0];
    r  = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SRA:  r = a >>> sh;
      default: r = '0;  // nop; mul is produced by the iterative path
    endcase
    return r;
  endfunction

  assign ready     = (state_q == S_IDLE);
  assign accept    = bus.valid_i & ready;
  assign last_iter = (state_q == S_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_step  = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

  always_comb begin
    state_nx = state_q;
    res_we   = 1'b0;
    res_nx   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && bus.ALUCtrl_i == OP_MUL) begin
          state_nx = S_MUL;
        end else if (accept) begin
          res_we = 1'b1;
          res_nx = alu_op(bus.ALUCtrl_i, signed'(bus.data1_i), signed'(bus.data2_i));
        end
      end
      S_MUL: begin
        if (last_iter) begin
          res_we   = 1'b1;
          res_nx   = acc_step;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // p0: control state, iteration counter and result register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
    end else begin
      state_q <= state_nx;
      vld_p1  <= res_we;
      if (accept)                 cnt_q <= '0;
      else if (state_q == S_MUL)  cnt_q <= cnt_q + 1'b1;
      if (res_we) begin
        res_p1  <= res_nx;
        zero_p1 <= (res_nx == '0);
      end
    end
  end

  // p0: multiplier datapath; a reset-discarded product is never published
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mcand_p0  <= signed'(bus.data1_i);
      mplier_p0 <= bus.data2_i;
      acc_p0    <= '0;
    end else if (state_q == S_MUL) begin
      acc_p0    <= acc_step;
      mcand_p0  <= mcand_p0 <<< 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = vld_p1;
  assign bus.data_o  = res_p1;
  assign bus.Zero_o  = zero_p1;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed and random ops on a 32-bit and an 8-bit
// instance, checked against an arithmetic reference model.
module tb_alu_multicycle;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) b32();
  alu_multicycle_if #(.WIDTH(8))  b8();

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5), .CNT_W(6)) dut32 (
    .clk_i(clk), .rst_i(rst_i), .bus(b32.slave));
  alu_multicycle #(.WIDTH(8), .SHAMT_W(3), .CNT_W(4)) dut8 (
    .clk_i(clk), .rst_i(rst_i), .bus(b8.slave));

  int checks = 0;
  int errors = 0;

  // Reference: plain modular arithmetic on 64-bit values, truncated to w bits.
  function automatic logic [63:0] model(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] mask, r;
    longint      sa;
    int          s;
    mask = (64'd1 << w) - 64'd1;
    a    = a & mask;
    b    = b & mask;
    s    = int'(b % 64'(w));
    sa   = a[w-1] ? longint'(a | ~mask) : longint'(a);
    case (op)
      3'd0: r = 64'd0;
      3'd1: r = a & b;
      3'd2: r = a ^ b;
      3'd3: r = a << s;
      3'd4: r = a + b;
      3'd5: r = a - b;
      3'd6: r = a * b;
      default: r = 64'(sa >>> s);
    endcase
    return r & mask;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op32(string tag, logic [2:0] op, logic [31:0] a, logic [31:0] b, bit disturb);
    int n, rdy_low;
    logic [63:0] exp;
    exp = model(32, op, {32'd0, a}, {32'd0, b});
    n = 0;
    @(negedge clk);
    while (!b32.ready_o && n < 100) begin @(negedge clk); n++; end
    check({tag, " ready"}, {63'd0, b32.ready_o}, 64'd1);
    b32.valid_i = 1'b1; b32.ALUCtrl_i = op; b32.data1_i = a; b32.data2_i = b;
    @(negedge clk);
    n = 1; rdy_low = 0;
    b32.valid_i = 1'b0;
    while (!b32.valid_o && n < 100) begin
      if (!b32.ready_o) rdy_low++;
      if (disturb) begin
        b32.valid_i = 1'($urandom); b32.ALUCtrl_i = 3'($urandom);
        b32.data1_i = $urandom; b32.data2_i = $urandom;
      end
      @(negedge clk);
      n++;
    end
    b32.valid_i = 1'b0;
    check({tag, " latency"}, 64'(n), (op == 3'd6) ? 64'd33 : 64'd1);
    check({tag, " data"}, {32'd0, b32.data_o}, exp);
    check({tag, " zero"}, {63'd0, b32.Zero_o}, {63'd0, exp == 64'd0});
    if (op == 3'd6) check({tag, " ready low cycles"}, 64'(rdy_low), 64'd32);
    @(negedge clk);
    check({tag, " single pulse"}, {63'd0, b32.valid_o}, 64'd0);
  endtask

  task automatic op8(string tag, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    int n, rdy_low;
    logic [63:0] exp;
    exp = model(8, op, {56'd0, a}, {56'd0, b});
    n = 0;
    @(negedge clk);
    while (!b8.ready_o && n < 100) begin @(negedge clk); n++; end
    check({tag, " ready"}, {63'd0, b8.ready_o}, 64'd1);
    b8.valid_i = 1'b1; b8.ALUCtrl_i = op; b8.data1_i = a; b8.data2_i = b;
    @(negedge clk);
    n = 1; rdy_low = 0;
    b8.valid_i = 1'b0;
    while (!b8.valid_o && n < 100) begin
      if (!b8.ready_o) rdy_low++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), (op == 3'd6) ? 64'd9 : 64'd1);
    check({tag, " data"}, {56'd0, b8.data_o}, exp);
    check({tag, " zero"}, {63'd0, b8.Zero_o}, {63'd0, exp == 64'd0});
    if (op == 3'd6) check({tag, " ready low cycles"}, 64'(rdy_low), 64'd8);
  endtask

  logic [2:0]  bo [5] = '{3'd4, 3'd5, 3'd1, 3'd2, 3'd0};
  logic [31:0] ba [5] = '{32'd7, 32'd5, 32'hF0F0F0F0, 32'hAAAAAAAA, 32'd0};
  logic [31:0] bb [5] = '{32'hFFFFFFF9, 32'd9, 32'hFF00FF00, 32'hFFFFFFFF, 32'd0};

  initial begin
    logic [63:0] exp;
    int stray;
    rst_i = 1'b0;
    b32.valid_i = 1'b1; b32.ALUCtrl_i = 3'd4; b32.data1_i = 32'd1; b32.data2_i = 32'd1;
    b8.valid_i = 1'b0;  b8.ALUCtrl_i = 3'd0;  b8.data1_i = 8'd0;   b8.data2_i = 8'd0;

    // Reset held with a request pending: nothing may come out.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset valid_o", {63'd0, b32.valid_o}, 64'd0);
      check("reset data_o", {32'd0, b32.data_o}, 64'd0);
      check("reset Zero_o", {63'd0, b32.Zero_o}, 64'd0);
      check("reset ready_o", {63'd0, b32.ready_o}, 64'd1);
    end
    check("reset8 ready_o", {63'd0, b8.ready_o}, 64'd1);
    check("reset8 Zero_o", {63'd0, b8.Zero_o}, 64'd0);
    b32.valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    check("post reset valid_o", {63'd0, b32.valid_o}, 64'd0);

    // Back-to-back single-cycle ops, one accept per cycle.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        exp = model(32, bo[i-1], {32'd0, ba[i-1]}, {32'd0, bb[i-1]});
        check("b2b valid_o", {63'd0, b32.valid_o}, 64'd1);
        check("b2b data_o", {32'd0, b32.data_o}, exp);
        check("b2b Zero_o", {63'd0, b32.Zero_o}, {63'd0, exp == 64'd0});
      end
      if (i < 5) begin
        b32.valid_i = 1'b1; b32.ALUCtrl_i = bo[i]; b32.data1_i = ba[i]; b32.data2_i = bb[i];
      end else begin
        b32.valid_i = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b trailing valid_o", {63'd0, b32.valid_o}, 64'd0);
    check("b2b hold data_o", {32'd0, b32.data_o}, 64'd0);

    op32("sll 1 by 0x25", 3'd3, 32'd1, 32'h25, 1'b0);
    op32("sra 0x80000000 by 4", 3'd7, 32'h80000000, 32'd4, 1'b0);
    op32("sra 0x40000000 by 31", 3'd7, 32'h40000000, 32'd31, 1'b0);
    op32("mul -3x7", 3'd6, 32'hFFFFFFFD, 32'd7, 1'b1);
    op32("mul 0x10000 sq", 3'd6, 32'h10000, 32'h10000, 1'b1);
    op32("add 1+1", 3'd4, 32'd1, 32'd1, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    b32.valid_i = 1'b1; b32.ALUCtrl_i = 3'd6; b32.data1_i = 32'd123; b32.data2_i = 32'd456;
    @(negedge clk);
    b32.valid_i = 1'b0;
    repeat (10) @(negedge clk);
    check("midmul busy", {63'd0, b32.ready_o}, 64'd0);
    rst_i = 1'b0;
    #1;
    check("midmul rst data_o", {32'd0, b32.data_o}, 64'd0);
    check("midmul rst Zero_o", {63'd0, b32.Zero_o}, 64'd0);
    check("midmul rst valid_o", {63'd0, b32.valid_o}, 64'd0);
    check("midmul rst ready_o", {63'd0, b32.ready_o}, 64'd1);
    @(negedge clk);
    rst_i = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b32.valid_o) stray++;
    end
    check("midmul no valid_o", 64'(stray), 64'd0);
    op32("add 2+3 after reset", 3'd4, 32'd2, 32'd3, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      op32("random32", op, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           1'(i % 2));
    end

    op8("w8 mul 0x0F*0x11", 3'd6, 8'h0F, 8'h11);
    op8("w8 add 0xFF+1", 3'd4, 8'hFF, 8'h01);
    op8("w8 sra 0x90 by 0x0B", 3'd7, 8'h90, 8'h0B);
    for (int i = 0; i < 20; i++) begin
      op8("random8", 3'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
